// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU definitions used by the ALU, its arbiter and the
// pipeline decoder.
//   ALU_W        - datapath width of the shared ALU
//   alu_op_t     - the twelve legal 4-bit operation codes
//   alu_op_legal - 1 when a raw 4-bit code is one of the legal operations
package alu_pkg;

  localparam int ALU_W = 32;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_NOR  = 4'b1100,
    OP_XOR  = 4'b1101,
    OP_BEQ  = 4'b1000,
    OP_BGTZ = 4'b1001,
    OP_BLEZ = 4'b1010,
    OP_BGEZ = 4'b1011,
    OP_BLTZ = 4'b1111
  } alu_op_t;

  function automatic logic alu_op_legal(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_XOR,
      OP_BEQ, OP_BGTZ, OP_BLEZ, OP_BGEZ, OP_BLTZ: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// alu: purely combinational 32-bit ALU.
//   a, b   in  operands (a is the only operand for the single-operand
//              branch tests and is treated as signed there)
//   op     in  4-bit operation code (alu_op_t)
//   result out operation result; 0 for an illegal code
//   zero   out result == 0 (for branch tests: 1 means branch taken)
//   err    out op is not a legal code
module alu
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [3:0]       op,
  output logic [ALU_W-1:0] result,
  output logic             zero,
  output logic             err
);

  logic signed [ALU_W-1:0] sa;
  logic signed [ALU_W-1:0] sb;

  assign sa = a;
  assign sb = b;

  // Branch tests produce 0 when taken and 1 when not taken, so the zero
  // flag doubles as the "taken" indication.
  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_SLT:  result = {{(ALU_W-1){1'b0}}, (sa < sb)};
      OP_NOR:  result = ~(a | b);
      OP_XOR:  result = a ^ b;
      OP_BEQ:  result = {{(ALU_W-1){1'b0}}, (a != b)};
      OP_BGTZ: result = {{(ALU_W-1){1'b0}}, !(sa > 0)};
      OP_BLEZ: result = {{(ALU_W-1){1'b0}}, !(sa <= 0)};
      OP_BGEZ: result = {{(ALU_W-1){1'b0}}, !(sa >= 0)};
      OP_BLTZ: result = {{(ALU_W-1){1'b0}}, !(sa < 0)};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
  assign err  = !alu_op_legal(op);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one alu between two requesters with a registered,
// tagged response one cycle after each transfer.
//   STARVE_LIMIT  contested cycles port 0 may win in a row before port 1
//                 is forced through (1..15)
//   clk, reset    clock, synchronous active-high reset
//   hold          freeze: no grants while high
//   reqN_valid/ready/a/b/op  request port N (port 0 has priority)
//   rsp_valid     response present this cycle (cannot be back-pressured)
//   rsp_id        port that issued the response
//   rsp_result    ALU result
//   rsp_zero      result == 0 (branch taken for branch-test ops)
//   rsp_err       op was not a legal code
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [ALU_W-1:0] req0_a,
  input  logic [ALU_W-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [ALU_W-1:0] req1_a,
  input  logic [ALU_W-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [ALU_W-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c >= LIMIT) ? LIMIT : c + 4'd1;
  endfunction

  logic [3:0]       starve_cnt;
  logic             open_p0;
  logic             both_p0;
  logic             pick1_p0;
  logic             xfer_p0;
  logic [ALU_W-1:0] a_p0;
  logic [ALU_W-1:0] b_p0;
  logic [3:0]       op_p0;
  logic [ALU_W-1:0] alu_result;
  logic             alu_zero;
  logic             alu_err;

  logic             rsp_valid_p1;
  logic             rsp_id_p1;
  logic [ALU_W-1:0] rsp_result_p1;
  logic             rsp_zero_p1;
  logic             rsp_err_p1;

  // ---- stage p0: arbitration and operand mux ----
  assign open_p0  = !reset && !hold;
  assign both_p0  = req0_valid && req1_valid;
  // Port 1 wins when alone, or when port 0 has used up its starvation budget.
  assign pick1_p0 = req1_valid && (!req0_valid || starve_cnt == LIMIT);

  // Readies only assert for a requesting port, so ready alone means transfer.
  assign req0_ready = open_p0 && req0_valid && !pick1_p0;
  assign req1_ready = open_p0 && pick1_p0;
  assign xfer_p0    = req0_ready || req1_ready;

  assign a_p0  = pick1_p0 ? req1_a  : req0_a;
  assign b_p0  = pick1_p0 ? req1_b  : req0_b;
  assign op_p0 = pick1_p0 ? req1_op : req0_op;

  alu u_alu (
    .a      (a_p0),
    .b      (b_p0),
    .op     (op_p0),
    .result (alu_result),
    .zero   (alu_zero),
    .err    (alu_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!hold) begin
      starve_cnt <= (both_p0 && req0_ready) ? sat_inc(starve_cnt) : 4'd0;
    end
  end

  // ---- stage p1: registered response ----
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_p1  <= 1'b0;
      rsp_id_p1     <= 1'b0;
      rsp_result_p1 <= '0;
      rsp_zero_p1   <= 1'b0;
      rsp_err_p1    <= 1'b0;
    end else begin
      rsp_valid_p1 <= xfer_p0;
      if (xfer_p0) begin
        rsp_id_p1     <= req1_ready;
        rsp_result_p1 <= alu_result;
        rsp_zero_p1   <= alu_zero;
        rsp_err_p1    <= alu_err;
      end
    end
  end

  assign rsp_valid  = rsp_valid_p1;
  assign rsp_id     = rsp_id_p1;
  assign rsp_result = rsp_result_p1;
  assign rsp_zero   = rsp_zero_p1;
  assign rsp_err    = rsp_err_p1;

endmodule
